// File: rtl/sv32_ptw.sv
// Sv32 two-level page table walker: one walk and one PTE read in flight at a time,
// returning the leaf PTE (4KB or 4MB superpage) or a page fault.
module sv32_ptw #(
   parameter int VPN_WIDTH  = 20,
   parameter int PPN_WIDTH  = 22,
   parameter int PA_WIDTH   = 34,
   parameter int ASID_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [PPN_WIDTH-1:0]  satp_ppn_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [VPN_WIDTH-1:0]  req_vpn_i,
   input  logic [ASID_WIDTH-1:0] req_asid_i,
   input  logic                  kill_i,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic [PA_WIDTH-1:0]   mem_req_pa_o,
   input  logic                  mem_resp_valid_i,
   input  logic [31:0]           mem_resp_pte_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [VPN_WIDTH-1:0]  resp_vpn_o,
   output logic [ASID_WIDTH-1:0] resp_asid_o,
   output logic [31:0]           resp_pte_o,
   output logic                  resp_is_superpage_o,
   output logic                  resp_page_fault_o
);

   localparam int LVL_W = VPN_WIDTH / 2;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_L1_REQ  = 3'd1;
   localparam logic [2:0] S_L1_WAIT = 3'd2;
   localparam logic [2:0] S_L0_REQ  = 3'd3;
   localparam logic [2:0] S_L0_WAIT = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;
   localparam logic [2:0] S_DRAIN   = 3'd6;

   logic [2:0]            state_q, state_d;
   logic [VPN_WIDTH-1:0]  vpn_q, vpn_d;
   logic [ASID_WIDTH-1:0] asid_q, asid_d;
   logic [PA_WIDTH-1:0]   pa_q, pa_d;
   logic [31:0]           pte_q, pte_d;
   logic                  super_q, super_d;
   logic                  fault_q, fault_d;

   // PTE decode of the word arriving on the memory response port
   logic pte_v, pte_r, pte_w, pte_x, pte_a;
   logic pte_bad, pte_leaf, at_level1, misaligned, walk_fault, walk_next;

   assign pte_v      = mem_resp_pte_i[0];
   assign pte_r      = mem_resp_pte_i[1];
   assign pte_w      = mem_resp_pte_i[2];
   assign pte_x      = mem_resp_pte_i[3];
   assign pte_a      = mem_resp_pte_i[6];
   assign pte_bad    = !pte_v || (!pte_r && pte_w);
   assign pte_leaf   = pte_r || pte_x;
   assign at_level1  = (state_q == S_L1_WAIT);
   assign misaligned = (mem_resp_pte_i[19:10] != '0);
   assign walk_fault = pte_bad
                     || (pte_leaf && (!pte_a || (at_level1 && misaligned)))
                     || (!pte_leaf && !at_level1);
   assign walk_next  = !pte_bad && !pte_leaf && at_level1;

   always_comb begin
      state_d = state_q;
      vpn_d   = vpn_q;
      asid_d  = asid_q;
      pa_d    = pa_q;
      pte_d   = pte_q;
      super_d = super_q;
      fault_d = fault_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               vpn_d   = req_vpn_i;
               asid_d  = req_asid_i;
               pa_d    = {satp_ppn_i, req_vpn_i[VPN_WIDTH-1 -: LVL_W], 2'b00};
               state_d = S_L1_REQ;
            end
         end
         S_L1_REQ, S_L0_REQ: begin
            if (kill_i) begin
               state_d = mem_req_ready_i ? S_DRAIN : S_IDLE;
            end else if (mem_req_ready_i) begin
               state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
            end
         end
         S_L1_WAIT, S_L0_WAIT: begin
            if (mem_resp_valid_i) begin
               // A kill coinciding with the response has nothing left to drain.
               if (kill_i) begin
                  state_d = S_IDLE;
               end else if (walk_next) begin
                  pa_d    = {mem_resp_pte_i[10 +: PPN_WIDTH], vpn_q[LVL_W-1:0], 2'b00};
                  state_d = S_L0_REQ;
               end else begin
                  pte_d   = walk_fault ? 32'h0 : mem_resp_pte_i;
                  super_d = at_level1 && !walk_fault;
                  fault_d = walk_fault;
                  state_d = S_RESP;
               end
            end else if (kill_i) begin
               state_d = S_DRAIN;
            end
         end
         S_RESP: begin
            if (kill_i || resp_ready_i) state_d = S_IDLE;
         end
         S_DRAIN: begin
            if (mem_resp_valid_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         vpn_q   <= '0;
         asid_q  <= '0;
         pa_q    <= '0;
         pte_q   <= '0;
         super_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         vpn_q   <= vpn_d;
         asid_q  <= asid_d;
         pa_q    <= pa_d;
         pte_q   <= pte_d;
         super_q <= super_d;
         fault_q <= fault_d;
      end
   end

   assign req_ready_o         = (state_q == S_IDLE);
   assign mem_req_valid_o     = (state_q == S_L1_REQ) || (state_q == S_L0_REQ);
   assign mem_req_pa_o        = pa_q;
   assign resp_valid_o        = (state_q == S_RESP);
   assign resp_vpn_o          = vpn_q;
   assign resp_asid_o         = asid_q;
   assign resp_pte_o          = pte_q;
   assign resp_is_superpage_o = super_q;
   assign resp_page_fault_o   = fault_q;

endmodule
